text_cursor_ctrl: RTL and testbench
===================================

TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

Interface
REQ-001 The block SHALL have parameter COLS, default 32, meaning characters per text row.
REQ-002 The block SHALL have parameter ROWS, default 4, meaning text rows in the buffer.
REQ-003 The block SHALL have parameter COL_W, default 5, meaning column address width; COLS <= 2**COL_W.
REQ-004 The block SHALL have parameter ROW_W, default 2, meaning row address width; ROWS <= 2**ROW_W.
REQ-005 The block SHALL have parameter FILL_CHAR, default 8'h20, meaning the byte written by clear and backspace.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: byte-ready level from the UART, which may stay high for many cycles.
REQ-009 The block SHALL have port rx_data, input, 8 bits: received byte, stable while rx_valid is high.
REQ-010 The block SHALL have port wr_en, output, 1 bit: text-RAM write strobe, one cycle per cell write.
REQ-011 The block SHALL have ports wr_row (ROW_W bits) and wr_col (COL_W bits), outputs: text-RAM write address.
REQ-012 The block SHALL have port wr_data, output, 8 bits: text-RAM write data.
REQ-013 The block SHALL have ports cur_row (ROW_W bits) and cur_col (COL_W bits), outputs: current cursor, for the 7-seg display.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a screen clear is in progress.
REQ-015 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-016 The block SHALL accept a byte only on a rising edge of rx_valid (rx_valid=1 while its registered copy is 0), capturing rx_data in that cycle (cycle N).
REQ-017 The block SHALL perform an IDLE-state byte's effects in cycle N+1: wr_en pulse and cursor update are both registered, latency 1.
REQ-018 For a printable byte (0x20..0x7E), the block SHALL write it at (cur_row,cur_col), then advance cur_col.
REQ-019 At cur_col=COLS-1, a printable byte SHALL set cur_col=0 and cur_row=cur_row+1; cur_row=ROWS-1 SHALL wrap to row 0 (no scroll).
REQ-020 A byte >= 0x80 SHALL be handled as printable with wr_data=8'h3F.
REQ-021 CR (0x0D) SHALL set cur_col=0, with no write.
REQ-022 LF (0x0A) SHALL set cur_col=0 and advance cur_row with wrap, with no write.
REQ-023 BS (0x08) with cur_col>0 SHALL decrement cur_col and write FILL_CHAR at the new position.
REQ-024 BS at cur_col=0 and cur_row>0 SHALL move the cursor to (cur_row-1, COLS-1) and write FILL_CHAR there.
REQ-025 BS at (0,0) SHALL do nothing.
REQ-026 FF (0x0C) SHALL move the FSM IDLE->CLEAR and assert busy from cycle N+1.
REQ-027 In CLEAR, the block SHALL write FILL_CHAR to every cell, row-major from (0,0), one cell per cycle (COLS*ROWS consecutive wr_en cycles).
REQ-028 After the last cell, the block SHALL set cursor (0,0), deassert busy and return to IDLE.
REQ-029 All other bytes 0x00..0x1F and 0x7F SHALL be ignored: no write, no cursor change.
REQ-030 A byte accepted in CLEAR SHALL go into a one-entry pending register; it SHALL be processed in the first IDLE cycle after the clear, with its effects registered one cycle later.
REQ-031 If a byte is accepted while pending is full, the byte SHALL be dropped and overflow SHALL pulse for exactly one cycle.
REQ-032 A byte accepted in the same cycle that pending is consumed SHALL be stored as the new pending byte (no overflow).
REQ-033 An FF received in CLEAR SHALL be held as pending and SHALL start a second full clear.
REQ-034 wr_en SHALL be 0 in every cycle with no write; wr_row, wr_col and wr_data are don't-care when wr_en=0.

Reset
REQ-035 Reset SHALL set asynchronously: FSM=IDLE, cursor (0,0), wr_en=0, busy=0, overflow=0, pending empty, edge register=0.
REQ-036 Reset asserted mid-clear SHALL abort the clear immediately, with no further writes.
REQ-037 After reset deasserts, an rx_valid already high SHALL count as a rising edge on the first clock.

Verification
REQ-038 Bench: "A","B" at reset -> writes (0,0)=0x41 and (0,1)=0x42, each one cycle after its edge; cursor ends at (0,2).
REQ-039 Bench: 32 printables then 96 more (defaults) -> the 128th write lands at (3,31); the cursor wraps to (0,0).
REQ-040 Bench: cursor (1,0) then BS -> write 0x20 at (0,31); cursor (0,31); a BS at (0,0) -> no write.
REQ-041 Bench: FF -> busy for exactly 128 cycles with 128 writes of 0x20; a "Z" sent mid-clear is written at (0,0) after busy falls.
REQ-042 Bench: two bytes during a clear -> the first is kept and the second pulses overflow once.
REQ-043 Bench: rx_valid held high for 10 cycles -> exactly one write.

Source files
------------

// File: rtl/text_cursor_ctrl.sv
// rtl/text_cursor_ctrl.sv - UART byte stream to text-RAM writer with cursor, backspace and screen clear.
module text_cursor_ctrl #(
  parameter int          COLS      = 32,
  parameter int          ROWS      = 4,
  parameter int          COL_W     = 5,
  parameter int          ROW_W     = 2,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             overflow
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           state_q, state_d;
  logic             rx_valid_q;
  logic             pend_vld_q, pend_vld_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic             wr_en_q, wr_en_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             overflow_q, overflow_d;
  logic             accept;
  logic             byte_vld;
  logic [7:0]       rx_byte;

  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (r == LAST_ROW) ? '0 : r + ROW_W'(1);
  endfunction

  assign accept = rx_valid & ~rx_valid_q;

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_data_d   = wr_data_q;
    overflow_d  = 1'b0;
    byte_vld    = 1'b0;
    rx_byte     = rx_data;

    case (state_q)
      S_IDLE: begin
        // A pending byte from the last clear goes first; a fresh edge refills the slot.
        if (pend_vld_q) begin
          byte_vld    = 1'b1;
          rx_byte     = pend_data_q;
          pend_vld_d  = accept;
          pend_data_d = rx_data;
        end else begin
          byte_vld = accept;
        end

        if (byte_vld) begin
          if (rx_byte[7] || (rx_byte >= 8'h20 && rx_byte != 8'h7F)) begin
            wr_en_d   = 1'b1;
            wr_row_d  = cur_row_q;
            wr_col_d  = cur_col_q;
            wr_data_d = rx_byte[7] ? 8'h3F : rx_byte;
            if (cur_col_q == LAST_COL) begin
              cur_col_d = '0;
              cur_row_d = next_row(cur_row_q);
            end else begin
              cur_col_d = cur_col_q + COL_W'(1);
            end
          end else begin
            case (rx_byte)
              8'h0D: cur_col_d = '0;
              8'h0A: begin
                cur_col_d = '0;
                cur_row_d = next_row(cur_row_q);
              end
              8'h08: begin
                if (cur_col_q != '0) begin
                  cur_col_d = cur_col_q - COL_W'(1);
                  wr_en_d   = 1'b1;
                  wr_row_d  = cur_row_q;
                  wr_col_d  = cur_col_q - COL_W'(1);
                  wr_data_d = FILL_CHAR;
                end else if (cur_row_q != '0) begin
                  cur_row_d = cur_row_q - ROW_W'(1);
                  cur_col_d = LAST_COL;
                  wr_en_d   = 1'b1;
                  wr_row_d  = cur_row_q - ROW_W'(1);
                  wr_col_d  = LAST_COL;
                  wr_data_d = FILL_CHAR;
                end
              end
              8'h0C: begin
                state_d   = S_CLEAR;
                wr_en_d   = 1'b1;
                wr_row_d  = '0;
                wr_col_d  = '0;
                wr_data_d = FILL_CHAR;
              end
              default: ;
            endcase
          end
        end
      end

      S_CLEAR: begin
        if (accept) begin
          if (pend_vld_q) begin
            overflow_d = 1'b1;
          end else begin
            pend_vld_d  = 1'b1;
            pend_data_d = rx_data;
          end
        end
        // The write address register doubles as the clear sweep index.
        if (wr_row_q == LAST_ROW && wr_col_q == LAST_COL) begin
          state_d   = S_IDLE;
          cur_row_d = '0;
          cur_col_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = FILL_CHAR;
          if (wr_col_q == LAST_COL) begin
            wr_col_d = '0;
            wr_row_d = wr_row_q + ROW_W'(1);
          end else begin
            wr_col_d = wr_col_q + COL_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_valid_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_data_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      wr_en_q     <= wr_en_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_data_q   <= wr_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_data  = wr_data_q;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;
  assign busy     = (state_q == S_CLEAR);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// tb/tb_text_cursor_ctrl.sv - randomized check of text_cursor_ctrl against a linear-position model.
module tb_text_cursor_ctrl;

  localparam int         COLS  = 32;
  localparam int         ROWS  = 4;
  localparam int         NCELL = COLS * ROWS;
  localparam logic [7:0] FILL  = 8'h20;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_data;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;

  text_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(5), .ROW_W(2), .FILL_CHAR(FILL)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cursor kept as one linear cell index; the screen is a flat array of NCELL cells.
  function automatic void model(input logic [7:0] b, output bit w, output int a, output logic [7:0] d);
    w = 0; a = 0; d = 8'h00;
    if (b >= 8'h80 || (b >= 8'h20 && b <= 8'h7E)) begin
      w = 1; a = pos; d = (b >= 8'h80) ? 8'h3F : b;
      pos = (pos + 1) % NCELL;
    end else if (b == 8'h0D) begin
      pos = pos - (pos % COLS);
    end else if (b == 8'h0A) begin
      pos = ((pos / COLS + 1) % ROWS) * COLS;
    end else if (b == 8'h08 && pos > 0) begin
      pos = pos - 1;
      w = 1; a = pos; d = FILL;
    end
  endfunction

  task automatic check_effect(input bit w, input int a, input logic [7:0] d);
    check("wr_en", wr_en, w);
    if (w) begin
      check("wr_addr", wr_row * COLS + wr_col, a);
      check("wr_data", wr_data, d);
    end
    check("cursor", cur_row * COLS + cur_col, pos);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    bit w; int a; logic [7:0] d;
    model(b, w, a, d);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    check_effect(w, a, d);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("hold_no_wr", wr_en, 1'b0);
    end
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("gap_no_wr", wr_en, 1'b0);
    end
  endtask

  // Entered at the negedge one cycle after the FF edge; returns at the first idle negedge.
  task automatic run_clear(input int inj_n, input logic [7:0] b0, input logic [7:0] b1);
    int busy_n = 0, wr_n = 0, bad = 0, ovf_n = 0;
    for (int c = 0; c < 400 && busy; c++) begin
      if (wr_en) begin
        if (wr_row * COLS + wr_col != wr_n || wr_data != FILL) bad++;
        wr_n++;
      end
      busy_n++;
      if (overflow) ovf_n++;
      rx_valid = (c == 40 && inj_n >= 1) || (c == 60 && inj_n >= 2);
      rx_data  = (c == 60) ? b1 : b0;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("clear_busy_cycles", busy_n, NCELL);
    check("clear_writes", wr_n, NCELL);
    check("clear_bad_cells", bad, 0);
    check("clear_overflow_pulses", ovf_n, (inj_n >= 2) ? 1 : 0);
    check("clear_end_wr_en", wr_en, 1'b0);
    pos = 0;
    check("clear_end_cursor", cur_row * COLS + cur_col, 0);
  endtask

  task automatic do_clear(input int inj_n, input logic [7:0] b0, input logic [7:0] b1);
    bit w; int a; logic [7:0] d;
    rx_valid = 1'b1;
    rx_data  = 8'h0C;
    @(negedge clk);
    check("clear_start_busy", busy, 1'b1);
    run_clear(inj_n, b0, b1);
    if (inj_n >= 1) begin
      if (b0 == 8'h0C) begin
        @(negedge clk);
        check("second_clear_busy", busy, 1'b1);
        run_clear(0, 8'h00, 8'h00);
      end else begin
        model(b0, w, a, d);
        @(negedge clk);
        check_effect(w, a, d);
      end
    end
    @(negedge clk);
    check("post_clear_idle", wr_en, 1'b0);
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pos   = 0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
      6: b = 8'($urandom_range(128, 255));
      7: begin
        b = 8'($urandom_range(0, 2));
        b = (b == 0) ? 8'h08 : (b == 1) ? 8'h0D : 8'h0A;
      end
      8: b = 8'($urandom_range(0, 31));
      default: b = 8'h7F;
    endcase
    if (b == 8'h0C) b = 8'h00;
    return b;
  endfunction

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_cursor", {cur_row, cur_col}, 7'd0);
    reset = 1'b0;
    @(negedge clk);

    send_byte(8'h41, 1, 1);
    send_byte(8'h42, 1, 1);
    check("ab_cur_col", cur_col, 5'd2);

    reset_dut();
    for (int i = 0; i < NCELL; i++) send_byte(8'($urandom_range(32, 126)), 1, 1);
    check("wrap_cursor", {cur_row, cur_col}, 7'd0);

    send_byte(8'h0A, 1, 1);
    check("lf_to_row1", {cur_row, cur_col}, {2'd1, 5'd0});
    send_byte(8'h08, 1, 1);
    check("bs_cursor", {cur_row, cur_col}, {2'd0, 5'd31});
    send_byte(8'h0D, 1, 1);
    send_byte(8'h08, 1, 1);

    send_byte(8'h48, 10, 2);

    do_clear(1, 8'h5A, 8'h00);
    do_clear(2, 8'h51, 8'h52);
    do_clear(1, 8'h0C, 8'h00);

    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h4B;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pos   = 0;
    begin
      bit w; int a; logic [7:0] d;
      model(8'h4B, w, a, d);
      @(negedge clk);
      check_effect(w, a, d);
    end
    rx_valid = 1'b0;
    @(negedge clk);

    rx_valid = 1'b1;
    rx_data  = 8'h0C;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_wr_en", wr_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cursor", {cur_row, cur_col}, 7'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pos   = 0;
    @(negedge clk);
    check("abort_no_wr", wr_en, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 39) == 0)
        do_clear($urandom_range(0, 2), 8'($urandom_range(32, 126)), rand_byte());
      else
        send_byte(rand_byte(), $urandom_range(1, 4), $urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
